// File: rtl/bus_tx_sequencer_pkg.sv
// Shared tag/state types for the Arduino byte-serialising path.
// Tag values match the core's shift-out encoding; 0 marks an illegal request.
package bus_tx_sequencer_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_PC   = 2'd1,
        TAG_MDR  = 2'd2,
        TAG_MAR  = 2'd3
    } bus_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
        ST_BYTE1 = 2'd2
    } tx_state_t;

    localparam int REQ_W = 18;

    // Returns {mar, mdr, pc}
    function automatic logic [2:0] tag_onehot(input bus_tag_t t);
        logic [2:0] oh;
        oh = 3'b000;
        case (t)
            TAG_PC:  oh = 3'b001;
            TAG_MDR: oh = 3'b010;
            TAG_MAR: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bus_tx_sequencer_fifo.sv
// Request queue: DEPTH x WIDTH sync FIFO, head visible combinationally on o_dat.
// Push while full is dropped; full reflects registered occupancy only.
module tx_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_tx_sequencer.sv
// Serialises queued 16-bit tagged words as two handshaked bytes; >=1 cycle from queue to out_valid.
// Core is backpressured only by a full queue; a stalled Arduino trips the watchdog and the word is abandoned.
module bus_tx_sequencer
    import bus_tx_sequencer_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int TIMEOUT   = 255,
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_tag,
    input  logic [15:0] req_data,
    input  logic        ard_receive_ready,
    output logic [7:0]  out_bus,
    output logic        out_valid,
    output logic        bus_pc,
    output logic        bus_mdr,
    output logic        bus_mar,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [REQ_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    bus_tag_t         w_head_tag;
    logic [15:0]      w_head_data;
    logic             w_head_legal;

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    bus_tag_t         r_hold_tag;
    logic [15:0]      r_hold_data;
    logic [7:0]       r_wait;
    logic [7:0]       w_wait_nxt;
    logic [7:0]       r_out_bus;
    logic             r_out_valid;
    logic [2:0]       r_tag_oh;
    logic             r_done;
    logic             r_error;

    logic             w_load;
    logic             w_illegal;
    logic             w_timeout;
    logic             w_done_nxt;
    bus_tag_t         w_src_tag;
    logic [15:0]      w_src_data;
    logic [7:0]       w_byte_first;
    logic [7:0]       w_byte_second;
    logic [7:0]       w_out_bus_nxt;
    logic [2:0]       w_tag_oh_nxt;

    tx_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .pop   (w_pop),
        .din   ({req_tag, req_data}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_head_tag   = bus_tag_t'(w_head[17:16]);
    assign w_head_data  = w_head[15:0];
    assign w_head_legal = (w_head_tag != TAG_NONE);

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_illegal   = 1'b0;
        w_timeout   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_illegal = !w_head_legal;
                    w_load    = w_head_legal;
                    if (w_head_legal) w_state_nxt = ST_BYTE0;
                end
                w_wait_nxt = '0;
            end
            ST_BYTE0, ST_BYTE1: begin
                if (ard_receive_ready) begin
                    w_wait_nxt = '0;
                    if (r_state == ST_BYTE0) begin
                        w_state_nxt = ST_BYTE1;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                        // Chain straight into the next word so bytes stay back-to-back
                        if (!w_empty) begin
                            w_pop     = 1'b1;
                            w_illegal = !w_head_legal;
                            w_load    = w_head_legal;
                            if (w_head_legal) w_state_nxt = ST_BYTE0;
                        end
                    end
                end else if (r_wait == WAIT_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_src_data    = w_load ? w_head_data : r_hold_data;
        w_src_tag     = w_load ? w_head_tag  : r_hold_tag;
        w_byte_first  = (MSB_FIRST != 0) ? w_src_data[15:8] : w_src_data[7:0];
        w_byte_second = (MSB_FIRST != 0) ? w_src_data[7:0]  : w_src_data[15:8];
        case (w_state_nxt)
            ST_BYTE0: w_out_bus_nxt = w_byte_first;
            ST_BYTE1: w_out_bus_nxt = w_byte_second;
            default:  w_out_bus_nxt = 8'h00;
        endcase
        w_tag_oh_nxt = (w_state_nxt == ST_IDLE) ? 3'b000 : tag_onehot(w_src_tag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_tag  <= TAG_NONE;
            r_hold_data <= '0;
            r_wait      <= '0;
            r_out_bus   <= '0;
            r_out_valid <= 1'b0;
            r_tag_oh    <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait      <= w_wait_nxt;
            r_out_bus   <= w_out_bus_nxt;
            r_out_valid <= (w_state_nxt != ST_IDLE);
            r_tag_oh    <= w_tag_oh_nxt;
            r_done      <= w_done_nxt;
            r_error     <= r_error | w_timeout | w_illegal;
            if (w_load) begin
                r_hold_tag  <= w_head_tag;
                r_hold_data <= w_head_data;
            end
        end
    end

    assign req_ready = !w_full;
    assign out_bus   = r_out_bus;
    assign out_valid = r_out_valid;
    assign bus_pc    = r_tag_oh[0];
    assign bus_mdr   = r_tag_oh[1];
    assign bus_mar   = r_tag_oh[2];
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_bus_tx_sequencer.sv
// Directed bench: dut_a uses MSB-first/TIMEOUT=255, dut_b LSB-first/TIMEOUT=4.
module tb_bus_tx_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        a_rst, a_req_valid, a_ard;
    logic [1:0]  a_req_tag;
    logic [15:0] a_req_data;
    logic        a_req_ready, a_out_valid, a_bus_pc, a_bus_mdr, a_bus_mar, a_busy, a_done, a_error;
    logic [7:0]  a_out_bus;

    logic        b_rst, b_req_valid, b_ard;
    logic [1:0]  b_req_tag;
    logic [15:0] b_req_data;
    logic        b_req_ready, b_out_valid, b_bus_pc, b_bus_mdr, b_bus_mar, b_busy, b_done, b_error;
    logic [7:0]  b_out_bus;

    bus_tx_sequencer #(.DEPTH(2), .TIMEOUT(255), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_tag(a_req_tag), .req_data(a_req_data), .ard_receive_ready(a_ard),
        .out_bus(a_out_bus), .out_valid(a_out_valid), .bus_pc(a_bus_pc), .bus_mdr(a_bus_mdr),
        .bus_mar(a_bus_mar), .busy(a_busy), .done(a_done), .error(a_error)
    );

    bus_tx_sequencer #(.DEPTH(2), .TIMEOUT(4), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_tag(b_req_tag), .req_data(b_req_data), .ard_receive_ready(b_ard),
        .out_bus(b_out_bus), .out_valid(b_out_valid), .bus_pc(b_bus_pc), .bus_mdr(b_bus_mdr),
        .bus_mar(b_bus_mar), .busy(b_busy), .done(b_done), .error(b_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_byte [5];
    logic [2:0] exp_tag  [5];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        a_rst = 1'b1; a_req_valid = 1'b0; a_ard = 1'b0; a_req_tag = 2'd0; a_req_data = 16'h0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_ard = 1'b0; b_req_tag = 2'd0; b_req_data = 16'h0;
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset state
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_bus",   a_out_bus, 8'h00);
        check("rst_tags",      {a_bus_mar, a_bus_mdr, a_bus_pc}, 3'b000);
        check("rst_busy",      a_busy, 0);
        check("rst_done",      a_done, 0);
        check("rst_error",     a_error, 0);
        check("rst_ready",     a_req_ready, 1);
        check("rst_b_ready",   b_req_ready, 1);

        // 1: single PC word, MSB first, Arduino always ready
        a_ard = 1'b1;
        a_req_valid = 1'b1; a_req_tag = 2'd1; a_req_data = 16'hA5C3;
        tick();
        a_req_valid = 1'b0;
        check("t1_busy_queued", a_busy, 1);
        check("t1_no_valid_yet", a_out_valid, 0);
        tick();
        check("t1_b0_valid", a_out_valid, 1);
        check("t1_b0_bus",   a_out_bus, 8'hA5);
        check("t1_b0_tags",  {a_bus_mar, a_bus_mdr, a_bus_pc}, 3'b001);
        tick();
        check("t1_b1_bus",   a_out_bus, 8'hC3);
        check("t1_b1_tags",  {a_bus_mar, a_bus_mdr, a_bus_pc}, 3'b001);
        check("t1_b1_done",  a_done, 0);
        tick();
        check("t1_done",     a_done, 1);
        check("t1_idle_valid", a_out_valid, 0);
        check("t1_idle_busy",  a_busy, 0);
        check("t1_idle_tags",  {a_bus_mar, a_bus_mdr, a_bus_pc}, 3'b000);
        tick();
        check("t1_done_pulse", a_done, 0);

        // 3: three words while Arduino stalled, then back-to-back drain
        a_ard = 1'b0;
        a_req_valid = 1'b1; a_req_tag = 2'd1; a_req_data = 16'h1A1B;
        tick();
        a_req_tag = 2'd2; a_req_data = 16'h2A2B;
        tick();
        check("t3_ready_one_queued", a_req_ready, 1);
        a_req_tag = 2'd3; a_req_data = 16'h3A3B;
        tick();
        check("t3_ready_full", a_req_ready, 0);
        check("t3_hold_byte",  a_out_bus, 8'h1A);
        a_req_tag = 2'd1; a_req_data = 16'h4A4B;
        tick();
        a_req_valid = 1'b0;
        check("t3_still_full", a_req_ready, 0);
        check("t3_stall_bus",  a_out_bus, 8'h1A);
        a_ard = 1'b1;
        exp_byte[0] = 8'h1B; exp_tag[0] = 3'b001;
        exp_byte[1] = 8'h2A; exp_tag[1] = 3'b010;
        exp_byte[2] = 8'h2B; exp_tag[2] = 3'b010;
        exp_byte[3] = 8'h3A; exp_tag[3] = 3'b100;
        exp_byte[4] = 8'h3B; exp_tag[4] = 3'b100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3_valid_%0d", i), a_out_valid, 1);
            check($sformatf("t3_bus_%0d", i),   a_out_bus, exp_byte[i]);
            check($sformatf("t3_tag_%0d", i),   {a_bus_mar, a_bus_mdr, a_bus_pc}, exp_tag[i]);
        end
        tick();
        check("t3_last_done", a_done, 1);
        check("t3_end_valid", a_out_valid, 0);
        check("t3_end_busy",  a_busy, 0);
        tick();
        check("t3_dropped_push", a_out_valid, 0);

        // 2: LSB first on dut_b
        b_ard = 1'b1;
        b_req_valid = 1'b1; b_req_tag = 2'd2; b_req_data = 16'h1234;
        tick();
        b_req_valid = 1'b0;
        tick();
        check("t2_b0_bus",  b_out_bus, 8'h34);
        check("t2_b0_tags", {b_bus_mar, b_bus_mdr, b_bus_pc}, 3'b010);
        tick();
        check("t2_b1_bus",  b_out_bus, 8'h12);
        check("t2_b1_tags", {b_bus_mar, b_bus_mdr, b_bus_pc}, 3'b010);
        tick();
        check("t2_done", b_done, 1);

        // 4: watchdog with TIMEOUT=4, second word still sent
        b_ard = 1'b0;
        b_req_valid = 1'b1; b_req_tag = 2'd1; b_req_data = 16'hBEEF;
        tick();
        b_req_tag = 2'd3; b_req_data = 16'h5566;
        tick();
        b_req_valid = 1'b0;
        tick(); tick(); tick();
        check("t4_no_err_yet", b_error, 0);
        check("t4_wait_bus",   b_out_bus, 8'hEF);
        tick();
        check("t4_err_set",    b_error, 1);
        check("t4_abandon",    b_out_valid, 0);
        check("t4_no_done",    b_done, 0);
        tick();
        check("t4_next_bus",   b_out_bus, 8'h66);
        check("t4_next_tags",  {b_bus_mar, b_bus_mdr, b_bus_pc}, 3'b100);
        b_ard = 1'b1;
        tick();
        check("t4_next_b1",    b_out_bus, 8'h55);
        tick();
        check("t4_next_done",  b_done, 1);
        check("t4_err_sticky", b_error, 1);
        check("t4_busy_clear", b_busy, 0);

        // 5: illegal tag dropped, following word normal
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        check("t5_err_cleared", b_error, 0);
        b_req_valid = 1'b1; b_req_tag = 2'd0; b_req_data = 16'hDEAD;
        tick();
        b_req_tag = 2'd1; b_req_data = 16'h0F0E;
        tick();
        b_req_valid = 1'b0;
        check("t5_err_set",   b_error, 1);
        check("t5_no_valid",  b_out_valid, 0);
        tick();
        check("t5_next_bus",  b_out_bus, 8'h0E);
        check("t5_next_tags", {b_bus_mar, b_bus_mdr, b_bus_pc}, 3'b001);
        tick();
        check("t5_next_b1",   b_out_bus, 8'h0F);
        tick();
        check("t5_done",      b_done, 1);

        // 6: reset during BYTE1 flushes queue
        a_ard = 1'b0;
        a_req_valid = 1'b1; a_req_tag = 2'd3; a_req_data = 16'h7788;
        tick();
        a_req_tag = 2'd1; a_req_data = 16'h9900;
        tick();
        a_req_valid = 1'b0;
        a_ard = 1'b1;
        tick();
        check("t6_in_byte1", a_out_bus, 8'h88);
        a_ard = 1'b0;
        a_rst = 1'b1;
        tick();
        check("t6_valid", a_out_valid, 0);
        check("t6_bus",   a_out_bus, 8'h00);
        check("t6_tags",  {a_bus_mar, a_bus_mdr, a_bus_pc}, 3'b000);
        check("t6_busy",  a_busy, 0);
        check("t6_ready", a_req_ready, 1);
        a_rst = 1'b0;
        tick();
        check("t6_flushed_valid", a_out_valid, 0);
        check("t6_flushed_busy",  a_busy, 0);
        check("t6_a_error", a_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
